alu_serial_master: RTL and testbench
====================================

Name: alu_serial_master

Overview:
Sequencing controller that drives the serial ALU on behalf of one parallel requester. It accepts one operation {A, B, op} over a valid/ready handshake and computes the 4-bit CRC. It serialises the 9-packet command frame onto sin, then deserialises the ALU response from sout into a one-cycle result pulse. A timeout counter guarantees a response even if the ALU stays silent.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waited in RX for the next start bit before a timeout response is issued
GAP_CYCLES, 0, idle-high cycles inserted between transmitted packets (0 = back-to-back)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; transfer on req_valid && req_ready
req_a  input  32  operand A
req_b  input  32  operand B
req_op  input  3  operation code, alu_pkg operation_t encoding
sin  output  1  serial line to ALU, registered, idle high
sout  input  1  serial line from ALU, idle high
rsp_valid  output  1  one-cycle response pulse
rsp_c  output  32  result, valid with rsp_valid
rsp_ctl  output  8  status byte returned by ALU
rsp_err  output  1  ALU returned CTL-only (error) response
rsp_timeout  output  1  no/incomplete response within TIMEOUT_CYCLES

Behaviour:
- Reset (async, rst_n=0): state IDLE, sin=1, req_ready=0 during reset then 1, rsp_valid=0, rsp_c=0, rsp_ctl=0, rsp_err=0, rsp_timeout=0, all counters 0. Reset mid-TX/RX aborts immediately with no response. sin returns high asynchronously.
- Packet format (11 cycles): start 0, type bit (0=DATA, 1=CTL), 8 data bits MSB first, stop 1.
- TX frame order: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] .. A[7:0] (8 DATA packets), then CTL packet {1'b0, op[2:0], crc[3:0]}. Total 99 cycles when GAP_CYCLES=0.
- CRC: polynomial x^4+x+1, init 4'b0000, over the 68-bit vector {B, A, 1'b1, op}, first bit d[67]. Per bit: fb=crc[3]^d; crc={crc[2:0],1'b0}^(fb?4'b0011:4'b0000). It may be computed in parallel at acceptance or serially, but it must be stable before the CTL packet.
- Latency: request accepted at edge N. The start bit of the first packet appears on sin after edge N+1. Operands are latched at acceptance, so later input changes are ignored.
- FSM: IDLE -> TX on accept. TX -> RX after the CTL stop bit. RX -> DONE on response complete or timeout. DONE -> IDLE after one cycle, with rsp_valid=1 during DONE.
- RX: a start bit is detected when sout==0 (X/Z treated as not-start). Each following cycle samples type, 8 data bits and stop.
  - First packet DATA: receive 5 packets total. rsp_c = bytes 0..3 (byte 0 is MSB), rsp_ctl = byte 4, rsp_err=0.
  - First packet CTL: single packet. rsp_ctl = its byte, rsp_c=0, rsp_err=1.
  - A later packet in a DATA response with type CTL is treated as byte 4 (response ends) and sets rsp_err=1.
- Timeout: a counter clears on each detected start bit and increments every RX cycle outside a packet. When it reaches TIMEOUT_CYCLES the block goes to DONE with rsp_timeout=1, rsp_err=1, rsp_c=0, rsp_ctl=0.
- Stop bit sampled 0: the packet is still accepted and the response proceeds. rsp_err is not affected.
- sout activity during TX is ignored. rsp_* outputs hold their values until the next DONE and only rsp_valid pulses.
- req_valid held while busy: not accepted, req_ready=0. Back-to-back requests: next accept is possible in the cycle after DONE.

Test Plan:
- A=0x00000001, B=0x00000002, add_op -> sin shows 99-cycle frame, first packet bits 0,0,00000000,1, CTL byte = {0,add_op,CRC model value}. ALU model returns C=0x00000003 -> rsp_valid one cycle, rsp_c=0x00000003, rsp_err=0.
- ALU model returns single CTL packet 0xC9 -> rsp_err=1, rsp_ctl=0xC9, rsp_c=0, exactly one rsp_valid.
- sout held high after TX, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after CTL stop bit, rsp_timeout=1.
- rst_n low at cycle 40 of TX -> sin=1 immediately, state IDLE, no rsp_valid, next request sends a complete frame.
- req_valid held continuously for 3 requests -> req_ready low from accept to DONE, three frames and three responses in order, operand changes during TX not reflected.
- CRC sweep: 500 random {A,B,op} -> transmitted crc[3:0] matches the alu_pkg reference CRC function in every case.

Source files
------------

// File: rtl/alu_serial_master.sv
// rtl/alu_serial_master.sv - serial ALU sequencing master: request in, 9-packet frame out, response back
module alu_serial_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_c,
    output logic [7:0]  rsp_ctl,
    output logic        rsp_err,
    output logic        rsp_timeout
);

    typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

    localparam logic [15:0] GAP      = 16'(GAP_CYCLES);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [3:0]  crc_q;

    logic [3:0]  tx_pkt;
    logic [3:0]  tx_bit;
    logic [15:0] gap_cnt;
    logic        tx_last;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_shift;
    logic        tx_val;

    logic        rx_active;
    logic [3:0]  rx_bit;
    logic [2:0]  rx_pkt;
    logic        rx_type;
    logic [7:0]  rx_byte;
    logic [31:0] rx_c;
    logic [15:0] tmo_cnt;

    // CRC x^4+x+1 over {B, A, 1, op}, MSB first, evaluated on the request operands at accept
    function automatic logic [3:0] crc_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [67:0] d;
        logic [3:0]  crc;
        logic        fb;
        d   = {b, a, 1'b1, op};
        crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ d[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    // Select the line level for the current packet/bit position of the outgoing frame
    always_comb begin
        tx_byte = {1'b0, op_q, crc_q};
        case (tx_pkt)
            4'd0:    tx_byte = b_q[31:24];
            4'd1:    tx_byte = b_q[23:16];
            4'd2:    tx_byte = b_q[15:8];
            4'd3:    tx_byte = b_q[7:0];
            4'd4:    tx_byte = a_q[31:24];
            4'd5:    tx_byte = a_q[23:16];
            4'd6:    tx_byte = a_q[15:8];
            4'd7:    tx_byte = a_q[7:0];
            default: tx_byte = {1'b0, op_q, crc_q};
        endcase
        tx_shift = tx_byte << (tx_bit - 4'd2);
        case (tx_bit)
            4'd0:    tx_val = 1'b0;
            4'd1:    tx_val = (tx_pkt == 4'd8);
            4'd10:   tx_val = 1'b1;
            default: tx_val = tx_shift[7];
        endcase
    end

    // Sequencer: accept, transmit frame, collect response or time out, pulse the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            sin         <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_c       <= 32'h0;
            rsp_ctl     <= 8'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 3'h0;
            crc_q       <= 4'h0;
            tx_pkt      <= 4'h0;
            tx_bit      <= 4'h0;
            gap_cnt     <= 16'h0;
            tx_last     <= 1'b0;
            rx_active   <= 1'b0;
            rx_bit      <= 4'h0;
            rx_pkt      <= 3'h0;
            rx_type     <= 1'b0;
            rx_byte     <= 8'h0;
            rx_c        <= 32'h0;
            tmo_cnt     <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    sin <= 1'b1;
                    if (req_valid && req_ready) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        op_q      <= req_op;
                        crc_q     <= crc_calc(req_a, req_b, req_op);
                        tx_pkt    <= 4'h0;
                        tx_bit    <= 4'h0;
                        gap_cnt   <= 16'h0;
                        tx_last   <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= TX;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                TX: begin
                    if (tx_last) begin
                        sin       <= 1'b1;
                        rx_active <= 1'b0;
                        rx_pkt    <= 3'h0;
                        rx_c      <= 32'h0;
                        tmo_cnt   <= 16'h0;
                        state     <= RX;
                    end else if (gap_cnt != 16'h0) begin
                        sin     <= 1'b1;
                        gap_cnt <= gap_cnt - 16'h1;
                    end else begin
                        sin <= tx_val;
                        if (tx_bit == 4'd10) begin
                            tx_bit <= 4'h0;
                            if (tx_pkt == 4'd8) begin
                                tx_last <= 1'b1;
                            end else begin
                                tx_pkt  <= tx_pkt + 4'h1;
                                gap_cnt <= GAP;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'h1;
                        end
                    end
                end
                RX: begin
                    sin <= 1'b1;
                    if (!rx_active) begin
                        if (sout == 1'b0) begin
                            rx_active <= 1'b1;
                            rx_bit    <= 4'h0;
                            tmo_cnt   <= 16'h0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            rsp_valid   <= 1'b1;
                            rsp_c       <= 32'h0;
                            rsp_ctl     <= 8'h0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'h1;
                        end
                    end else begin
                        rx_bit <= rx_bit + 4'h1;
                        if (rx_bit == 4'd0) begin
                            rx_type <= sout;
                        end else if (rx_bit <= 4'd8) begin
                            rx_byte <= {rx_byte[6:0], sout};
                        end else begin
                            // stop bit slot: its level is not checked
                            rx_active <= 1'b0;
                            if (rx_type || rx_pkt == 3'd4) begin
                                rsp_valid   <= 1'b1;
                                rsp_c       <= rx_c;
                                rsp_ctl     <= rx_byte;
                                rsp_err     <= rx_type;
                                rsp_timeout <= 1'b0;
                                state       <= DONE;
                            end else begin
                                case (rx_pkt)
                                    3'd0:    rx_c[31:24] <= rx_byte;
                                    3'd1:    rx_c[23:16] <= rx_byte;
                                    3'd2:    rx_c[15:8]  <= rx_byte;
                                    default: rx_c[7:0]   <= rx_byte;
                                endcase
                                rx_pkt <= rx_pkt + 3'h1;
                            end
                        end
                    end
                end
                DONE: begin
                    sin       <= 1'b1;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_master.sv
// tb/tb_alu_serial_master.sv - randomized scoreboard bench for alu_serial_master with a serial ALU model
module tb_alu_serial_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic        sin;
    logic        sout;
    logic        rsp_valid;
    logic [31:0] rsp_c;
    logic [7:0]  rsp_ctl;
    logic        rsp_err;
    logic        rsp_timeout;

    alu_serial_master #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .sin(sin), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_ctl(rsp_ctl),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [98:0] bits;
        logic [3:0]  crc;
        int          start;
        int          mode;
        logic [31:0] c;
        logic [7:0]  ctl;
        bit          bad_stop;
    } frame_t;

    typedef struct {
        logic [31:0] c;
        logic [7:0]  ctl;
        bit          err;
        bit          tmo;
        int          at;
    } rsp_t;

    frame_t frame_q[$];
    frame_t alu_q[$];
    rsp_t   exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;

    int          cur_mode;
    logic [7:0]  cur_ctl;
    bit          cur_bad;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // CRC as remainder of {B,A,1,op} * x^4 divided by x^4+x+1
    function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [71:0] v;
        v = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic [98:0] frame_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [63:0] ba;
        logic [98:0] f;
        logic [7:0]  by;
        ba = {b, a};
        f  = '0;
        for (int p = 0; p < 9; p++) begin
            if (p < 8) by = ba[63 - 8*p -: 8];
            else       by = {1'b0, op, crc_ref(a, b, op)};
            f = {f[87:0], 1'b0, (p == 8), by, 1'b1};
        end
        return f;
    endfunction

    // Acceptance tracker and sin frame checker
    frame_t      nf;
    rsp_t        nr;
    frame_t      cur_fr;
    bit          fr_active = 0;
    int          fr_idx;
    logic [98:0] got;
    bit          busy = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fr_active = 0;
            busy      = 0;
        end else begin
            if (busy && req_ready) viol++;
            if (rsp_valid) busy = 0;
            if (req_valid && req_ready) begin
                nf.bits     = frame_ref(req_a, req_b, req_op);
                nf.crc      = crc_ref(req_a, req_b, req_op);
                nf.start    = cyc + 2;
                nf.mode     = cur_mode;
                nf.c        = alu_ref(req_a, req_b, req_op);
                nf.ctl      = cur_ctl;
                nf.bad_stop = cur_bad;
                frame_q.push_back(nf);
                nr.c   = (cur_mode == 0) ? nf.c : 32'h0;
                nr.ctl = (cur_mode == 2) ? 8'h00 : cur_ctl;
                nr.err = (cur_mode != 0);
                nr.tmo = (cur_mode == 2);
                nr.at  = (cur_mode == 2) ? cyc + 101 + TMO : -1;
                exp_q.push_back(nr);
                busy = 1;
            end
            if (!fr_active && frame_q.size() > 0 && cyc == frame_q[0].start) begin
                cur_fr    = frame_q.pop_front();
                fr_active = 1;
                fr_idx    = 0;
            end
            if (fr_active) begin
                got = {got[97:0], sin};
                fr_idx++;
                if (fr_idx == 99) begin
                    checks++;
                    if (got !== cur_fr.bits) begin
                        failures++;
                        $display("FAIL tx_frame actual=%h expected=%h", got, cur_fr.bits);
                    end
                    check("tx_crc", 32'(got[4:1]), 32'(cur_fr.crc));
                    alu_q.push_back(cur_fr);
                    fr_active = 0;
                end
            end
        end
    end

    // Response scoreboard monitor
    rsp_t e;
    bit   prev_v = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (rsp_valid) begin
                check("rsp_pulse_width", 32'(prev_v), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=rsp_valid expected=none at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_c", rsp_c, e.c);
                    check("rsp_ctl", 32'(rsp_ctl), 32'(e.ctl));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    check("ready_in_done", 32'(req_ready), 32'h0);
                    if (e.at >= 0) check("timeout_latency", 32'(cyc), 32'(e.at));
                end
            end
            prev_v = rsp_valid;
        end
    end

    // Serial ALU model: answers each completed frame according to its mode
    frame_t act;
    task automatic send_pkt(input bit typ, input logic [7:0] by, input bit stop);
        logic [10:0] p;
        p = {1'b0, typ, by, stop};
        for (int j = 10; j >= 0; j--) begin
            sout = p[j];
            @(posedge clk); #1;
        end
        sout = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_idx;
        sout = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && alu_q.size() > 0) begin
                act = alu_q.pop_front();
                if (act.mode != 2) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    if (act.mode == 1) begin
                        send_pkt(1'b1, act.ctl, 1'b1);
                    end else begin
                        bad_idx = act.bad_stop ? int'($urandom_range(0, 4)) : 99;
                        for (int i = 0; i < 4; i++)
                            send_pkt(1'b0, act.c[31 - 8*i -: 8], bad_idx != i);
                        send_pkt(1'b0, act.ctl, bad_idx != 4);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input int mode, input logic [7:0] ctl, input bit bad, input bit keep);
        int  n;
        bit  ok;
        cur_mode  = mode;
        cur_ctl   = ctl;
        cur_bad   = bad;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        n  = 0;
        ok = 0;
        while (n < 3000 && !ok) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_wait actual=no_ready expected=ready within 3000 cycles");
        end
        @(posedge clk); #1;
        if (keep) begin
            repeat (30) @(posedge clk);
            #1;
            req_a  = $urandom;
            req_b  = $urandom;
            req_op = 3'($urandom);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && exp_q.size() > 0) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL response_wait actual=%0d pending expected=0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int m;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        req_op    = 3'h0;
        cur_mode  = 0;
        cur_ctl   = 8'h0;
        cur_bad   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sin", 32'(sin), 32'h1);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_c", rsp_c, 32'h0);
        check("reset_rsp_ctl", 32'(rsp_ctl), 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", 32'(req_ready), 32'h1);

        send(32'h1, 32'h2, 3'd0, 0, 8'h5A, 0, 0);
        wait_idle();
        send($urandom, $urandom, 3'($urandom), 1, 8'hC9, 0, 0);
        wait_idle();
        send($urandom, $urandom, 3'($urandom), 2, 8'h00, 0, 0);
        wait_idle();
        send($urandom, $urandom, 3'($urandom), 0, 8'($urandom), 1, 0);
        wait_idle();

        send($urandom, $urandom, 3'($urandom), 0, 8'($urandom), 0, 0);
        repeat (40) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midtx_reset_sin", 32'(sin), 32'h1);
        check("midtx_reset_ready", 32'(req_ready), 32'h0);
        check("midtx_reset_valid", 32'(rsp_valid), 32'h0);
        exp_q.delete();
        frame_q.delete();
        alu_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_midtx_reset", 32'(req_ready), 32'h1);
        send($urandom, $urandom, 3'($urandom), 0, 8'($urandom), 0, 0);
        wait_idle();

        send($urandom, $urandom, 3'($urandom), 0, 8'($urandom), 0, 1);
        send($urandom, $urandom, 3'($urandom), 1, 8'($urandom), 0, 1);
        send($urandom, $urandom, 3'($urandom), 0, 8'($urandom), 0, 0);
        wait_idle();

        for (int i = 0; i < 500; i++) begin
            m = $urandom_range(0, 9);
            m = (m < 7) ? 1 : (m < 9) ? 0 : 2;
            send($urandom, $urandom, 3'($urandom), m, 8'($urandom), ($urandom_range(0, 7) == 0), 0);
        end
        wait_idle();

        check("ready_while_busy", 32'(viol), 32'h0);
        check("frames_drained", 32'(frame_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
